// File: rtl/burst_write_master_pkg.sv
// Shared CSR map, bit positions and FSM state type for the burst write master.
package write_master_pkg;

    localparam logic [3:0] CSR_CONTROL   = 4'd0;
    localparam logic [3:0] CSR_STATUS    = 4'd1;
    localparam logic [3:0] CSR_LENGTH    = 4'd2;
    localparam logic [3:0] CSR_BASE      = 4'd3;
    localparam logic [3:0] CSR_USER_DATA = 4'd4;
    localparam logic [3:0] CSR_PUSH      = 4'd5;
    localparam logic [3:0] CSR_REMAINING = 4'd6;

    localparam int unsigned CTRL_GO     = 0;
    localparam int unsigned CTRL_FIXED  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_DONE     = 0;
    localparam int unsigned STAT_EMPTY    = 1;
    localparam int unsigned STAT_FULL     = 2;
    localparam int unsigned STAT_BUSY     = 3;
    localparam int unsigned STAT_IRQ      = 4;
    localparam int unsigned STAT_OVERFLOW = 5;
    localparam int unsigned STAT_USED_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_BURST
    } state_t;

endpackage

// File: rtl/burst_write_master_if.sv
// Avalon-MM burst write port between the master and its memory/peripheral target.
interface burst_write_master_if #(
    parameter int unsigned DATAWIDTH       = 32,
    parameter int unsigned ADDRESSWIDTH    = 32,
    parameter int unsigned BURSTCOUNTWIDTH = 3
);
    logic [ADDRESSWIDTH-1:0]    master_address;
    logic                       master_write;
    logic [DATAWIDTH/8-1:0]     master_byteenable;
    logic [BURSTCOUNTWIDTH-1:0] master_burstcount;
    logic [DATAWIDTH-1:0]       master_writedata;
    logic                       master_waitrequest;

    modport master (
        output master_address, master_write, master_byteenable,
               master_burstcount, master_writedata,
        input  master_waitrequest
    );

    modport slave (
        input  master_address, master_write, master_byteenable,
               master_burstcount, master_writedata,
        output master_waitrequest
    );
endinterface

// File: rtl/burst_write_master_fifo.sv
// Show-ahead single-clock FIFO; head word is visible on rdata whenever not empty.
module write_master_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  rd,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  full,
    output logic                  empty
);
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (used == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (used == '0);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            used <= used + (DEPTH_LOG2 + 1)'(do_wr) - (DEPTH_LOG2 + 1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/burst_write_master.sv
// CSR-programmed Avalon-MM burst write master fed from an internal FIFO,
// with optional fixed-address mode and a maskable completion interrupt.
module burst_write_master
    import write_master_pkg::*;
#(
    parameter int unsigned DATAWIDTH       = 32,
    parameter int unsigned ADDRESSWIDTH    = 32,
    parameter int unsigned FIFODEPTH       = 32,
    parameter int unsigned FIFODEPTH_LOG2  = 5,
    parameter int unsigned MAXBURSTCOUNT   = 4,
    parameter int unsigned BURSTCOUNTWIDTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  avs_csr_address,
    input  logic        avs_csr_write,
    input  logic [31:0] avs_csr_writedata,
    input  logic        avs_csr_read,
    output logic [31:0] avs_csr_readdata,
    burst_write_master_if.master avm,
    output logic        irq
);
    localparam int unsigned BYTES  = DATAWIDTH / 8;
    localparam int unsigned BSHIFT = $clog2(BYTES);
    localparam int unsigned LANES  = DATAWIDTH / 32;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t state, next_state;

    logic                       ctrl_fixed;
    logic                       ctrl_irq_en;
    logic [31:0]                length_reg;
    logic [ADDRESSWIDTH-1:0]    base_reg;
    logic [DATAWIDTH-1:0]       user_word;
    logic [LANE_W-1:0]          lane;
    logic [31:0]                remaining;
    logic [ADDRESSWIDTH-1:0]    addr;
    logic                       fixed_active;
    logic [BURSTCOUNTWIDTH-1:0] burst_len;
    logic [BURSTCOUNTWIDTH-1:0] beat;
    logic                       irq_pending;
    logic                       overflow;
    logic [31:0]                csr_rdata;

    logic [DATAWIDTH-1:0]       fifo_head;
    logic [FIFODEPTH_LOG2:0]    fifo_used;
    logic                       fifo_full;
    logic                       fifo_empty;

    logic                       write_req;
    logic                       go;
    logic                       push_req;
    logic                       accept;
    logic                       last_beat;
    logic                       data_ready;
    logic [31:0]                words_left;
    logic [BURSTCOUNTWIDTH-1:0] n_next;

    assign go       = avs_csr_write && (avs_csr_address == CSR_CONTROL)
                      && avs_csr_writedata[CTRL_GO] && (state == ST_IDLE);
    assign push_req = avs_csr_write && (avs_csr_address == CSR_PUSH) && avs_csr_writedata[0];
    assign accept   = write_req & ~avm.master_waitrequest;
    assign last_beat = accept && (beat == burst_len - 1'b1);

    // Fixed mode always issues single beats; otherwise cap at the remaining word count.
    assign words_left = remaining >> BSHIFT;
    always_comb begin
        n_next = '0;
        if (fixed_active)
            n_next = BURSTCOUNTWIDTH'(1);
        else if (words_left >= MAXBURSTCOUNT)
            n_next = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        else
            n_next = words_left[BURSTCOUNTWIDTH-1:0];
    end
    assign data_ready = (32'(fifo_used) >= 32'(n_next));

    write_master_fifo #(
        .WIDTH      (DATAWIDTH),
        .DEPTH      (FIFODEPTH),
        .DEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push_req),
        .wdata (user_word),
        .rd    (accept),
        .rdata (fifo_head),
        .used  (fifo_used),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        write_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go && (length_reg != '0)) next_state = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (data_ready) next_state = ST_BURST;
            end
            ST_BURST: begin
                write_req = 1'b1;
                if (last_beat)
                    next_state = (remaining == 32'(BYTES)) ? ST_IDLE : ST_WAIT_DATA;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_fixed   <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            length_reg   <= '0;
            base_reg     <= '0;
            user_word    <= '0;
            lane         <= '0;
            remaining    <= '0;
            addr         <= '0;
            fixed_active <= 1'b0;
            burst_len    <= '0;
            beat         <= '0;
            irq_pending  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (avs_csr_write) begin
                case (avs_csr_address)
                    CSR_CONTROL: begin
                        ctrl_fixed  <= avs_csr_writedata[CTRL_FIXED];
                        ctrl_irq_en <= avs_csr_writedata[CTRL_IRQ_EN];
                    end
                    CSR_STATUS: begin
                        if (avs_csr_writedata[STAT_IRQ])      irq_pending <= 1'b0;
                        if (avs_csr_writedata[STAT_OVERFLOW]) overflow    <= 1'b0;
                    end
                    CSR_LENGTH: length_reg <= avs_csr_writedata & ~32'(BYTES - 1);
                    CSR_BASE:   base_reg   <= ADDRESSWIDTH'(avs_csr_writedata) & ~ADDRESSWIDTH'(BYTES - 1);
                    CSR_USER_DATA: begin
                        user_word[lane*32 +: 32] <= avs_csr_writedata;
                        lane <= (32'(lane) == LANES - 1) ? '0 : lane + 1'b1;
                    end
                    CSR_PUSH: begin
                        if (avs_csr_writedata[0]) begin
                            lane <= '0;
                            if (fifo_full) overflow <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (go) begin
                addr         <= base_reg;
                remaining    <= length_reg;
                fixed_active <= avs_csr_writedata[CTRL_FIXED];
                if (length_reg == '0) irq_pending <= 1'b1;
            end

            if ((state == ST_WAIT_DATA) && data_ready) begin
                burst_len <= n_next;
                beat      <= '0;
            end

            if (accept) begin
                beat      <= beat + 1'b1;
                remaining <= remaining - 32'(BYTES);
                if (last_beat) begin
                    if (!fixed_active) addr <= addr + (ADDRESSWIDTH'(burst_len) << BSHIFT);
                    if (remaining == 32'(BYTES)) irq_pending <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (avs_csr_address)
            CSR_CONTROL: begin
                csr_rdata[CTRL_FIXED]  = ctrl_fixed;
                csr_rdata[CTRL_IRQ_EN] = ctrl_irq_en;
            end
            CSR_STATUS: begin
                csr_rdata[STAT_DONE]              = (remaining == '0) && (state == ST_IDLE);
                csr_rdata[STAT_EMPTY]             = fifo_empty;
                csr_rdata[STAT_FULL]              = fifo_full;
                csr_rdata[STAT_BUSY]              = (state != ST_IDLE);
                csr_rdata[STAT_IRQ]               = irq_pending;
                csr_rdata[STAT_OVERFLOW]          = overflow;
                csr_rdata[STAT_USED_LSB +: 8]     = 8'(fifo_used);
            end
            CSR_LENGTH:    csr_rdata = length_reg;
            CSR_BASE:      csr_rdata = 32'(base_reg);
            CSR_REMAINING: csr_rdata = remaining;
            default:       csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             avs_csr_readdata <= '0;
        else if (avs_csr_read) avs_csr_readdata <= csr_rdata;
    end

    assign avm.master_address    = addr;
    assign avm.master_write      = write_req;
    assign avm.master_byteenable = '1;
    assign avm.master_burstcount = burst_len;
    assign avm.master_writedata  = fifo_head;
    assign irq                   = irq_pending & ctrl_irq_en;

endmodule

// File: tb/tb_burst_write_master.sv
// Directed bench for burst_write_master: a transfer-level model predicts bursts and data.
module tb_burst_write_master;
    import write_master_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  avs_csr_address;
    logic        avs_csr_write;
    logic [31:0] avs_csr_writedata;
    logic        avs_csr_read;
    logic [31:0] avs_csr_readdata;
    logic        irq;

    burst_write_master_if #(.DATAWIDTH(32), .ADDRESSWIDTH(32), .BURSTCOUNTWIDTH(3)) bus ();

    burst_write_master #(
        .DATAWIDTH(32), .ADDRESSWIDTH(32), .FIFODEPTH(32),
        .FIFODEPTH_LOG2(5), .MAXBURSTCOUNT(4), .BURSTCOUNTWIDTH(3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_csr_address   (avs_csr_address),
        .avs_csr_write     (avs_csr_write),
        .avs_csr_writedata (avs_csr_writedata),
        .avs_csr_read      (avs_csr_read),
        .avs_csr_readdata  (avs_csr_readdata),
        .avm               (bus.master),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned cnt;
    } burst_t;

    burst_t      exp_bursts[$];
    burst_t      seen_bursts[$];
    logic [31:0] model_fifo[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    bit          stall_en = 1'b0;
    int          accepts = 0;
    int unsigned mon_beat = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [2:0]  prev_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level expectation: split the byte length into bursts.
    task automatic plan(input logic [31:0] base, input int unsigned len, input bit fixed);
        logic [31:0] a = base;
        int unsigned rem = len;
        int unsigned n;
        while (rem > 0) begin
            n = fixed ? 1 : ((rem / 4 >= 4) ? 4 : rem / 4);
            exp_bursts.push_back('{a, n});
            if (!fixed) a = a + n * 4;
            rem = rem - n * 4;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && bus.master_write) begin
            if (exp_bursts.size() == 0) begin
                chk("unexpected_write", 32'(bus.master_write), 32'd0);
            end else begin
                if (prev_stall) begin
                    chk("stall_addr", bus.master_address, prev_addr);
                    chk("stall_cnt", 32'(bus.master_burstcount), 32'(prev_cnt));
                    chk("stall_data", bus.master_writedata, prev_data);
                end else if (mon_beat == 0) begin
                    seen_bursts.push_back('{bus.master_address, 32'(bus.master_burstcount)});
                end
                chk("addr", bus.master_address, exp_bursts[0].addr);
                chk("burstcount", 32'(bus.master_burstcount), exp_bursts[0].cnt);
                if (model_fifo.size() == 0) chk("model_underflow", 32'(model_fifo.size()), 32'd1);
                else chk("writedata", bus.master_writedata, model_fifo[0]);
                chk("byteenable", 32'(bus.master_byteenable), 32'hF);
                prev_addr = bus.master_address;
                prev_cnt  = bus.master_burstcount;
                prev_data = bus.master_writedata;
                prev_stall = bus.master_waitrequest;
                if (!bus.master_waitrequest) begin
                    accepts++;
                    if (model_fifo.size() > 0) void'(model_fifo.pop_front());
                    mon_beat++;
                    if (mon_beat == exp_bursts[0].cnt) begin
                        void'(exp_bursts.pop_front());
                        mon_beat = 0;
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        bus.master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_csr_address   = a;
        avs_csr_writedata = d;
        avs_csr_write     = 1'b1;
        @(negedge clk);
        avs_csr_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_csr_address = a;
        avs_csr_read    = 1'b1;
        @(negedge clk);
        avs_csr_read    = 1'b0;
        d = avs_csr_readdata;
    endtask

    task automatic push_word(input logic [31:0] w);
        csr_write(CSR_USER_DATA, w);
        csr_write(CSR_PUSH, 32'd1);
        if (model_fifo.size() < 32) model_fifo.push_back(w);
    endtask

    task automatic wait_idle();
        logic [31:0] s = 32'hFFFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            csr_read(CSR_STATUS, s);
            if (!s[STAT_BUSY]) break;
        end
        if (s[STAT_BUSY]) chk("idle_timeout", s, 32'd0);
    endtask

    task automatic finish_xfer();
        logic [31:0] s;
        chk("irq_raised", 32'(irq), 32'd1);
        csr_read(CSR_STATUS, s);
        chk("status_done", s, 32'h13);
        csr_write(CSR_STATUS, 32'h10);
        chk("irq_cleared", 32'(irq), 32'd0);
        chk("model_bursts_drained", 32'(exp_bursts.size()), 32'd0);
        chk("model_fifo_drained", 32'(model_fifo.size()), 32'd0);
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len, input bit fixed);
        csr_write(CSR_BASE, base);
        csr_write(CSR_LENGTH, len);
        plan(base, len, fixed);
        seen_bursts.delete();
        accepts = 0;
        csr_write(CSR_CONTROL, fixed ? 32'h7 : 32'h5);
    endtask

    initial begin
        logic [31:0] r;
        bit          saw;
        reset = 1'b1;
        avs_csr_address = '0; avs_csr_write = 1'b0; avs_csr_writedata = '0; avs_csr_read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        chk("rst_write", 32'(bus.master_write), 32'd0);
        chk("rst_addr", bus.master_address, 32'd0);
        chk("rst_burstcount", 32'(bus.master_burstcount), 32'd0);
        chk("rst_byteenable", 32'(bus.master_byteenable), 32'hF);
        chk("rst_writedata", bus.master_writedata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        csr_read(CSR_STATUS, r);
        chk("rst_status", r, 32'h03);

        // Two full bursts.
        csr_write(CSR_CONTROL, 32'h4);
        for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
        start(32'h1000, 32, 1'b0);
        wait_idle();
        chk("t1_nbursts", 32'(seen_bursts.size()), 32'd2);
        if (seen_bursts.size() == 2) begin
            chk("t1_b0_addr", seen_bursts[0].addr, 32'h1000);
            chk("t1_b0_cnt", seen_bursts[0].cnt, 32'd4);
            chk("t1_b1_addr", seen_bursts[1].addr, 32'h1010);
            chk("t1_b1_cnt", seen_bursts[1].cnt, 32'd4);
        end
        finish_xfer();

        // Short tail burst.
        for (int i = 0; i < 6; i++) push_word(32'h20 + 32'(i));
        start(32'h1000, 24, 1'b0);
        wait_idle();
        chk("t2_nbursts", 32'(seen_bursts.size()), 32'd2);
        if (seen_bursts.size() == 2) begin
            chk("t2_b1_addr", seen_bursts[1].addr, 32'h1010);
            chk("t2_b1_cnt", seen_bursts[1].cnt, 32'd2);
        end
        finish_xfer();

        // Fixed-location single beats.
        for (int i = 0; i < 3; i++) push_word(32'h30 + 32'(i));
        start(32'h2000, 12, 1'b1);
        wait_idle();
        chk("t3_nbursts", 32'(seen_bursts.size()), 32'd3);
        foreach (seen_bursts[i]) begin
            chk("t3_addr", seen_bursts[i].addr, 32'h2000);
            chk("t3_cnt", seen_bursts[i].cnt, 32'd1);
        end
        csr_read(CSR_CONTROL, r);
        chk("t3_control_rd", r, 32'h6);
        finish_xfer();
        csr_write(CSR_CONTROL, 32'h4);

        // Random stalls.
        for (int i = 0; i < 4; i++) push_word(32'h40 + 32'(i));
        stall_en = 1'b1;
        start(32'h3000, 16, 1'b0);
        wait_idle();
        stall_en = 1'b0;
        chk("t4_pops", 32'(accepts), 32'd4);
        finish_xfer();

        // Starved start waits for data.
        push_word(32'h50); push_word(32'h51);
        start(32'h4000, 16, 1'b0);
        repeat (10) @(negedge clk);
        chk("t5_no_write", 32'(accepts), 32'd0);
        csr_read(CSR_STATUS, r);
        chk("t5_status_wait", r, 32'h0208);
        push_word(32'h52); push_word(32'h53);
        wait_idle();
        chk("t5_pops", 32'(accepts), 32'd4);
        if (seen_bursts.size() > 0) chk("t5_addr", seen_bursts[0].addr, 32'h4000);
        finish_xfer();

        // Zero-length go.
        start(32'h5000, 0, 1'b0);
        chk("t6_irq_next", 32'(irq), 32'd1);
        chk("t6_no_traffic", 32'(accepts), 32'd0);
        finish_xfer();

        // Overflow.
        for (int i = 0; i < 33; i++) push_word(32'h100 + 32'(i));
        csr_read(CSR_STATUS, r);
        chk("t7_status_ovf", r, 32'h2025);
        csr_write(CSR_STATUS, 32'h20);
        csr_read(CSR_STATUS, r);
        chk("t7_status_w1c", r, 32'h2005);

        // Reset during a burst.
        stall_en = 1'b1;
        start(32'h6000, 128, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 50 && !saw; i++) begin
            @(negedge clk);
            saw = bus.master_write;
        end
        chk("t8_burst_started", 32'(saw), 32'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("t8_rst_write", 32'(bus.master_write), 32'd0);
        chk("t8_rst_addr", bus.master_address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall_en = 1'b0;
        exp_bursts.delete();
        model_fifo.delete();
        mon_beat = 0;
        csr_read(CSR_STATUS, r);
        chk("t8_status_flushed", r, 32'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
